// File: rtl/wdt_controller_mips.sv
// rtl/wdt_controller_mips.sv - watchdog timer that pulses the MIPS core reset on expiry
// Counts down from the wdt_set period, restarts on kick, fires a fixed-width reset pulse then re-arms.
module wdt_controller_mips #(
  parameter int          CNT_WIDTH          = 32,
  parameter int          RESET_PULSE_CYCLES = 4,
  parameter int unsigned DEFAULT_PERIOD     = 0,
  parameter int          TO_CNT_WIDTH       = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_period_w_en,
  input  logic [CNT_WIDTH-1:0]    i_period,
  input  logic                    i_kick,
  input  logic                    i_timeout_clr,
  output logic                    o_cpu_reset,
  output logic                    o_timeout,
  output logic [TO_CNT_WIDTH-1:0] o_timeout_cnt,
  output logic [CNT_WIDTH-1:0]    o_count,
  output logic [1:0]              o_state
);

  localparam int PW = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
  localparam logic [PW-1:0]        PULSE_LAST  = PW'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DEF_PERIOD  = CNT_WIDTH'(DEFAULT_PERIOD);

  typedef enum logic [1:0] {
    S_DISABLED = 2'b00,
    S_COUNTING = 2'b01,
    S_FIRING   = 2'b10,
    S_INVALID  = 2'b11
  } state_t;

  localparam state_t RESET_STATE = (DEFAULT_PERIOD == 0) ? S_DISABLED : S_COUNTING;

  state_t                  state, state_n;
  logic [CNT_WIDTH-1:0]    period_reg, period_n;
  logic [CNT_WIDTH-1:0]    count_n;
  logic [PW-1:0]           pulse, pulse_n;
  logic                    cpu_reset_n, timeout_n, expiry;
  logic [TO_CNT_WIDTH-1:0] to_cnt_n;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= RESET_STATE;
      period_reg    <= DEF_PERIOD;
      o_count       <= DEF_PERIOD;
      pulse         <= '0;
      o_cpu_reset   <= 1'b0;
      o_timeout     <= 1'b0;
      o_timeout_cnt <= '0;
    end else begin
      state         <= state_n;
      period_reg    <= period_n;
      o_count       <= count_n;
      pulse         <= pulse_n;
      o_cpu_reset   <= cpu_reset_n;
      o_timeout     <= timeout_n;
      o_timeout_cnt <= to_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    period_n    = period_reg;
    count_n     = o_count;
    pulse_n     = pulse;
    cpu_reset_n = o_cpu_reset;
    timeout_n   = i_timeout_clr ? 1'b0 : o_timeout;
    to_cnt_n    = o_timeout_cnt;
    expiry      = 1'b0;

    case (state)
      S_DISABLED: begin
        count_n = '0;
        if (i_period_w_en) begin
          period_n = i_period;
          if (i_period != '0) begin
            count_n = i_period;
            state_n = S_COUNTING;
          end
        end
      end
      S_COUNTING: begin
        if (i_period_w_en) begin
          period_n = i_period;
          count_n  = i_period;
          if (i_period == '0) state_n = S_DISABLED;
        end else if (i_kick) begin
          count_n = period_reg;
        end else if (o_count == '0) begin
          expiry = 1'b1;
        end else begin
          count_n = o_count - CNT_WIDTH'(1);
        end
      end
      S_FIRING: begin
        count_n = '0;
        if (pulse == '0) begin
          cpu_reset_n = 1'b0;
          count_n     = period_reg;
          state_n     = S_COUNTING;
        end else begin
          pulse_n = pulse - PW'(1);
        end
      end
      default: begin
        state_n     = S_DISABLED;
        cpu_reset_n = 1'b0;
        count_n     = '0;
      end
    endcase

    // Expiry outranks a coincident flag clear.
    if (expiry) begin
      state_n     = S_FIRING;
      cpu_reset_n = 1'b1;
      pulse_n     = PULSE_LAST;
      timeout_n   = 1'b1;
      if (o_timeout_cnt != '1) to_cnt_n = o_timeout_cnt + TO_CNT_WIDTH'(1);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_wdt_controller_mips.sv
// tb/tb_wdt_controller_mips.sv - directed scoreboard bench for wdt_controller_mips
// A behavioural model queues the expected outputs of each edge; they are popped after the edge.
module tb_wdt_controller_mips;

  localparam int CW = 32;
  localparam int TW = 2;
  localparam int PULSE = 4;

  logic          clk = 1'b0;
  logic          rst, pw, kick, clr;
  logic [CW-1:0] period;
  logic          cpu_reset, timeout;
  logic [TW-1:0] to_cnt;
  logic [CW-1:0] count;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;

  logic [37:0] exp_q[$];

  // model state
  logic [1:0]    m_state;
  logic [CW-1:0] m_count, m_period;
  int            m_hi;
  logic          m_rst, m_to;
  logic [TW-1:0] m_tocnt;

  wdt_controller_mips #(
    .CNT_WIDTH(CW), .RESET_PULSE_CYCLES(PULSE), .DEFAULT_PERIOD(0), .TO_CNT_WIDTH(TW)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_period_w_en(pw), .i_period(period), .i_kick(kick),
    .i_timeout_clr(clr), .o_cpu_reset(cpu_reset), .o_timeout(timeout),
    .o_timeout_cnt(to_cnt), .o_count(count), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic w, input logic [CW-1:0] p,
                       input logic k, input logic c);
    logic fire;
    fire = 1'b0;
    if (r) begin
      m_state = 2'b00; m_count = '0; m_period = '0; m_hi = 0;
      m_rst = 1'b0; m_to = 1'b0; m_tocnt = '0;
    end else begin
      case (m_state)
        2'b00: if (w) begin
          m_period = p;
          if (p != 0) begin m_count = p; m_state = 2'b01; end
        end
        2'b01: begin
          if (w) begin
            m_period = p; m_count = p;
            if (p == 0) m_state = 2'b00;
          end else if (k) m_count = m_period;
          else if (m_count == 0) fire = 1'b1;
          else m_count = m_count - 1;
        end
        default: begin
          m_hi = m_hi - 1;
          if (m_hi == 0) begin m_rst = 1'b0; m_count = m_period; m_state = 2'b01; end
        end
      endcase
      if (fire) begin
        m_state = 2'b10; m_rst = 1'b1; m_hi = PULSE; m_to = 1'b1;
        if (m_tocnt != 2'b11) m_tocnt = m_tocnt + 1;
      end else if (c) m_to = 1'b0;
    end
    exp_q.push_back({m_state, m_rst, m_to, m_tocnt, m_count});
  endtask

  task automatic cycle(input logic r = 0, input logic w = 0, input logic [CW-1:0] p = 0,
                       input logic k = 0, input logic c = 0);
    logic [37:0] e;
    model(r, w, p, k, c);
    rst = r; pw = w; period = p; kick = k; clr = c;
    @(posedge clk);
    #1;
    rst = 0; pw = 0; period = 0; kick = 0; clr = 0;
    e = exp_q.pop_front();
    check("cycle", {26'd0, state, cpu_reset, timeout, to_cnt, count}, {26'd0, e});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1; pw = 0; period = 0; kick = 0; clr = 0;
    cycle(.r(1));
    cycle(.r(1));
    check("reset_state", state, 2'b00);
    check("reset_count", count, 0);

    // disabled: kicks ignored
    for (int i = 0; i < 100; i++) begin
      cycle(.k(i % 3 == 0));
      check("dis_alive", {state, cpu_reset, count != 0}, 4'b0000);
    end

    // basic expiry at t0+6, 4-cycle pulse
    cycle(.w(1), .p(5));
    check("load5", count, 5);
    idle(5);
    check("count0", count, 0);
    idle(1);
    check("fire_rise", cpu_reset, 1);
    idle(3);
    check("fire_hold", cpu_reset, 1);
    idle(1);
    check("fire_end", {state, cpu_reset, timeout, to_cnt}, {2'b01, 1'b0, 1'b1, 2'd1});
    check("reload", count, 5);

    // periodic kicks keep it alive
    for (int i = 0; i < 200; i++) begin
      cycle(.k(i % 4 == 3));
      check("kick_alive", {cpu_reset, count >= 1}, 2'b01);
    end
    idle(5);
    cycle(.k(1));
    check("kick_at0", {cpu_reset, count}, {1'b0, 32'd5});

    // write + kick at zero, then disable
    idle(5);
    cycle(.w(1), .p(9), .k(1));
    check("wr_kick_at0", {state, cpu_reset, count}, {2'b01, 1'b0, 32'd9});
    cycle(.w(1), .p(0));
    check("disable", {state, count}, {2'b00, 32'd0});

    // firing ignores writes and kicks
    cycle(.w(1), .p(5));
    idle(6);
    cycle(.w(1), .p(3), .k(1));
    idle(2);
    check("fire_ign", cpu_reset, 1);
    idle(1);
    check("old_period", {state, cpu_reset, count}, {2'b01, 1'b0, 32'd5});
    idle(6);
    cycle(.r(1));
    check("rst_mid_fire", {state, cpu_reset, timeout, to_cnt, count}, 38'd0);

    // saturation and sticky flag
    cycle(.w(1), .p(1));
    idle(30);
    check("sat", to_cnt, 3);
    idle(1);
    cycle(.c(1));
    check("clr_on_expiry", {cpu_reset, timeout}, 2'b11);
    cycle(.c(1));
    check("clr_later", timeout, 0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wdt_controller_mips.md
Name: wdt_controller_mips

Overview:
Watchdog timer controller for the single-cycle MIPS core. It holds the wait period programmed by the wdt_set instruction: the main control unit raises the write enable, and the period value comes from register-file read data. It counts down every clock and restarts on a kick. On expiry it drives a registered, fixed-width reset pulse into the core, then re-arms itself. Integration logic ORs o_cpu_reset with the system reset to form the core reset.

Parameters:
CNT_WIDTH, 32, width of period register and down-counter
RESET_PULSE_CYCLES, 4, number of cycles o_cpu_reset is held high per timeout (>=1)
DEFAULT_PERIOD, 0, period loaded at reset; 0 means the watchdog starts disabled
TO_CNT_WIDTH, 8, width of the saturating timeout event counter

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  synchronous active-high reset
i_period_w_en  input  1  period write strobe (wdt_set decode)
i_period  input  CNT_WIDTH  new period value (register-file read data)
i_kick  input  1  restart countdown from the stored period
i_timeout_clr  input  1  clears o_timeout sticky flag
o_cpu_reset  output  1  registered reset pulse to the core
o_timeout  output  1  sticky flag: at least one timeout occurred
o_timeout_cnt  output  TO_CNT_WIDTH  saturating count of timeouts
o_count  output  CNT_WIDTH  current countdown value
o_state  output  2  FSM state: 00 DISABLED, 01 COUNTING, 10 FIRING

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is synchronous and active-high; all state changes occur on the rising edge of i_clk.
- Reset values:
  - period_reg = DEFAULT_PERIOD; o_count = DEFAULT_PERIOD.
  - o_state = DISABLED if DEFAULT_PERIOD==0, else COUNTING.
  - o_cpu_reset = 0, o_timeout = 0, o_timeout_cnt = 0, pulse counter = 0.
  - i_reset asserted mid-FIRING ends the pulse: o_cpu_reset is 0 after that edge.
- DISABLED:
  - o_count holds 0; i_kick is ignored.
  - i_period_w_en with i_period!=0: period_reg = o_count = i_period, next state COUNTING.
  - i_period_w_en with i_period==0: period_reg = 0, stay DISABLED.
- COUNTING, per-edge priority (highest first):
  1. i_period_w_en: period_reg = o_count = i_period; if i_period==0, go to DISABLED with o_count = 0.
  2. i_kick: o_count = period_reg.
  3. o_count==0: expiry (see below).
  4. Otherwise: o_count decrements by 1 (no wrap; the 0 case is handled by expiry).
- Expiry:
  - Next state FIRING; o_cpu_reset = 1; pulse counter = RESET_PULSE_CYCLES-1.
  - o_timeout = 1.
  - o_timeout_cnt increments, saturating at all-ones.
- Timing: a load or kick at edge t0 leaves o_count = P. If no further kick, o_cpu_reset rises at edge t0+P+1.
- FIRING:
  - o_cpu_reset = 1; i_kick and i_period_w_en are ignored; o_count holds 0.
  - The pulse counter decrements each cycle. When it is 0: o_cpu_reset = 0, o_count = period_reg, next state COUNTING.
  - o_cpu_reset is high for exactly RESET_PULSE_CYCLES cycles.
- Sticky flag:
  - i_timeout_clr clears o_timeout on the next edge.
  - If the clear coincides with an expiry edge, the set wins.
- State encoding 11 is unreachable. If entered, it returns to DISABLED on the next edge with o_cpu_reset = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Disabled default: reset (DEFAULT_PERIOD=0), run 100 cycles with i_kick pulses -> o_state=00, o_count=0, o_cpu_reset=0 throughout.
2. Basic expiry: write i_period=5 at edge t0, no kicks -> o_count 5,4,3,2,1,0; o_cpu_reset=1 from edge t0+6 for exactly 4 cycles; o_timeout=1; o_timeout_cnt=1; o_count=5 and state 01 after the pulse.
3. Kick keeps alive: period=5, kick every 4 cycles for 200 cycles -> o_cpu_reset never asserts, o_count never below 1. Period=5 with a kick at o_count=0 -> reloads to 5, no fire.
4. Simultaneous events and disable:
   - i_period_w_en=1 with i_period=9 and i_kick=1 at o_count=0 -> o_count=9, no fire.
   - Write i_period=0 while COUNTING -> state 00, o_count=0.
5. FIRING and reset corners:
   - During FIRING, write i_period=3 and pulse i_kick -> both ignored; pulse still 4 cycles; reload uses the old period.
   - i_reset in pulse cycle 2 -> o_cpu_reset=0 after that edge, all outputs at reset values.
6. Flag and saturation (TO_CNT_WIDTH=2, period=1): force 5 timeouts -> o_timeout_cnt sticks at 3. Assert i_timeout_clr on an expiry edge -> o_timeout stays 1; assert it on a later non-expiry edge -> o_timeout=0.
